// File: rtl/sprite_motion_ctrl.sv
// N-sprite position controller: per-sprite position, speed, frame divider and path mode,
// one sequential update pass per frame pulse, runtime reconfiguration while idle.
module sprite_motion_ctrl #(
  parameter int         N_SPR     = 4,
  parameter int         CORDW     = 16,
  parameter int         H_RES     = 640,
  parameter int         SPR_DRAWW = 128,
  parameter int         SPDW      = 4,
  parameter int         DIVW      = 4,
  parameter int         INIT_X    = 640,
  parameter int         INIT_Y    = 240,
  parameter int         DEF_SPD   = 2,
  parameter int         DEF_DIV   = 1,
  parameter logic [1:0] DEF_MODE  = 2'b01,
  localparam int        IDXW      = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix_n,
  input  logic                   frame,
  input  logic                   pause,
  input  logic                   cfg_we,
  input  logic [IDXW-1:0]        cfg_idx,
  input  logic [CORDW-1:0]       cfg_x,
  input  logic [CORDW-1:0]       cfg_y,
  input  logic [SPDW-1:0]        cfg_spd,
  input  logic [DIVW-1:0]        cfg_div,
  input  logic [1:0]             cfg_mode,
  input  logic                   clr_err,
  output logic                   cfg_ready,
  output logic [N_SPR*CORDW-1:0] sprx,
  output logic [N_SPR*CORDW-1:0] spry,
  output logic [N_SPR-1:0]       dir,
  output logic                   upd_done,
  output logic                   cfg_err,
  output logic                   overrun,
  output logic                   dbg_state
);

  localparam logic signed [CORDW-1:0] C_HRES = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] C_LEFT = CORDW'(-SPR_DRAWW);
  localparam logic signed [CORDW-1:0] C_MAX  = CORDW'(H_RES - SPR_DRAWW);
  localparam logic signed [CORDW-1:0] C_ZERO = '0;

  typedef enum logic {S_IDLE = 1'b0, S_UPDATE = 1'b1} state_t;

  state_t                  r_state, w_state_nx;
  logic [IDXW-1:0]         r_idx, w_idx_nx;
  logic                    r_upd_done, w_upd_done_nx;
  logic                    r_cfg_err, r_overrun;

  logic signed [CORDW-1:0] r_x    [N_SPR];
  logic [CORDW-1:0]        r_y    [N_SPR];
  logic [SPDW-1:0]         r_spd  [N_SPR];
  logic [DIVW-1:0]         r_div  [N_SPR];
  logic [DIVW-1:0]         r_dcnt [N_SPR];
  logic [1:0]              r_mode [N_SPR];
  logic [N_SPR-1:0]        r_dir;

  logic                    w_cfg_ok, w_err_set, w_ovr_set, w_visit, w_hit;
  logic signed [CORDW-1:0] w_cur_x, w_spd_ext, w_plus, w_minus, w_step_x;
  logic                    w_step_dir;

  // Writes are only legal between passes, so a config load and a sprite visit never collide.
  assign w_cfg_ok  = cfg_we && (r_state == S_IDLE) &&
                     ({1'b0, cfg_idx} < (IDXW+1)'(N_SPR));
  assign w_err_set = cfg_we && !w_cfg_ok;
  assign w_ovr_set = frame && (r_state == S_UPDATE);
  assign w_visit   = (r_state == S_UPDATE) && !pause;
  assign w_hit     = (r_dcnt[r_idx] == r_div[r_idx]);

  assign w_cur_x   = r_x[r_idx];
  assign w_spd_ext = {{(CORDW-SPDW){1'b0}}, r_spd[r_idx]};
  assign w_plus    = w_cur_x + w_spd_ext;
  assign w_minus   = w_cur_x - w_spd_ext;

  always_comb begin
    w_step_x   = w_cur_x;
    w_step_dir = r_dir[r_idx];
    case (r_mode[r_idx])
      2'b01: w_step_x = (w_cur_x <= C_LEFT) ? C_HRES : w_minus;
      2'b10: w_step_x = (w_cur_x >= C_HRES) ? C_LEFT : w_plus;
      2'b11: begin
        if (r_dir[r_idx]) begin
          if (w_plus >= C_MAX) begin
            w_step_x   = C_MAX;
            w_step_dir = 1'b0;
          end else begin
            w_step_x = w_plus;
          end
        end else begin
          if (w_minus <= C_ZERO) begin
            w_step_x   = C_ZERO;
            w_step_dir = 1'b1;
          end else begin
            w_step_x = w_minus;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx    = r_state;
    w_idx_nx      = r_idx;
    w_upd_done_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame) begin
          w_state_nx = S_UPDATE;
          w_idx_nx   = '0;
        end
      end
      S_UPDATE: begin
        if (r_idx == IDXW'(N_SPR - 1)) begin
          w_state_nx    = S_IDLE;
          w_idx_nx      = '0;
          w_upd_done_nx = 1'b1;
        end else begin
          w_idx_nx = r_idx + IDXW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_upd_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_upd_done <= w_upd_done_nx;
    end
  end

  // Error flags are sticky: a same-cycle set beats clr_err so no event is lost.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_cfg_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_err_set)    r_cfg_err <= 1'b1;
      else if (clr_err) r_cfg_err <= 1'b0;
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int k = 0; k < N_SPR; k++) begin
        r_x[k]    <= CORDW'(INIT_X);
        r_y[k]    <= CORDW'(INIT_Y);
        r_spd[k]  <= SPDW'(DEF_SPD);
        r_div[k]  <= DIVW'(DEF_DIV);
        r_dcnt[k] <= '0;
        r_mode[k] <= DEF_MODE;
      end
      r_dir <= '0;
    end else if (w_cfg_ok) begin
      r_x[cfg_idx]    <= cfg_x;
      r_y[cfg_idx]    <= cfg_y;
      r_spd[cfg_idx]  <= cfg_spd;
      r_div[cfg_idx]  <= cfg_div;
      r_dcnt[cfg_idx] <= '0;
      r_mode[cfg_idx] <= cfg_mode;
      r_dir[cfg_idx]  <= cfg_mode[1];
    end else if (w_visit) begin
      if (w_hit) begin
        r_dcnt[r_idx] <= '0;
        r_x[r_idx]    <= w_step_x;
        r_dir[r_idx]  <= w_step_dir;
      end else begin
        r_dcnt[r_idx] <= r_dcnt[r_idx] + DIVW'(1);
      end
    end
  end

  for (genvar k = 0; k < N_SPR; k++) begin : g_pack
    assign sprx[k*CORDW +: CORDW] = r_x[k];
    assign spry[k*CORDW +: CORDW] = r_y[k];
  end

  assign dir       = r_dir;
  assign cfg_ready = (r_state == S_IDLE);
  assign upd_done  = r_upd_done;
  assign cfg_err   = r_cfg_err;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: reference model feeding an expected-position queue per pass,
// a table of configure-then-run vectors, and hand sequences for errors, pause and reset.
module tb_sprite_motion_ctrl;

  localparam int N     = 3;
  localparam int CORDW = 16;
  localparam int SPDW  = 4;
  localparam int DIVW  = 4;
  localparam int IDXW  = 2;
  localparam int HRES  = 640;
  localparam int DRAWW = 128;
  localparam int XMAX  = HRES - DRAWW;
  localparam int W     = 2*N*CORDW + N;

  logic                   clk_pix, rst_pix_n, frame, pause, cfg_we, clr_err;
  logic [IDXW-1:0]        cfg_idx;
  logic [CORDW-1:0]       cfg_x, cfg_y;
  logic [SPDW-1:0]        cfg_spd;
  logic [DIVW-1:0]        cfg_div;
  logic [1:0]             cfg_mode;
  logic                   cfg_ready, upd_done, cfg_err, overrun, dbg_state;
  logic [N*CORDW-1:0]     sprx, spry;
  logic [N-1:0]           dir;

  sprite_motion_ctrl #(.N_SPR(N)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .pause(pause),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_spd(cfg_spd), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .clr_err(clr_err),
    .cfg_ready(cfg_ready), .sprx(sprx), .spry(spry), .dir(dir), .upd_done(upd_done),
    .cfg_err(cfg_err), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int m_x[N], m_y[N], m_spd[N], m_div[N], m_mode[N], m_cnt[N], m_dir[N];
  int lc_idx, lc_x, lc_y, lc_spd, lc_div, lc_mode;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_x[k] = 640; m_y[k] = 240; m_spd[k] = 2; m_div[k] = 1;
      m_mode[k] = 1; m_cnt[k] = 0; m_dir[k] = 0;
    end
  endfunction

  function automatic void model_cfg(input int idx, x, y, spd, dv, mode);
    if (idx < N) begin
      m_x[idx] = x; m_y[idx] = y; m_spd[idx] = spd; m_div[idx] = dv;
      m_mode[idx] = mode; m_cnt[idx] = 0; m_dir[idx] = (mode >= 2) ? 1 : 0;
    end
  endfunction

  function automatic void model_frame();
    if (pause) return;
    for (int k = 0; k < N; k++) begin
      if (m_cnt[k] == m_div[k]) begin
        m_cnt[k] = 0;
        case (m_mode[k])
          1: m_x[k] = (m_x[k] <= -DRAWW) ? HRES : m_x[k] - m_spd[k];
          2: m_x[k] = (m_x[k] >= HRES) ? -DRAWW : m_x[k] + m_spd[k];
          3: begin
            if (m_dir[k] == 1) begin
              if (m_x[k] + m_spd[k] >= XMAX) begin m_x[k] = XMAX; m_dir[k] = 0; end
              else m_x[k] = m_x[k] + m_spd[k];
            end else begin
              if (m_x[k] - m_spd[k] <= 0) begin m_x[k] = 0; m_dir[k] = 1; end
              else m_x[k] = m_x[k] - m_spd[k];
            end
          end
          default: ;
        endcase
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endfunction

  function automatic logic [W-1:0] model_pack();
    logic [N*CORDW-1:0] px, py;
    logic [N-1:0]       pd;
    for (int k = 0; k < N; k++) begin
      px[k*CORDW +: CORDW] = CORDW'(m_x[k]);
      py[k*CORDW +: CORDW] = CORDW'(m_y[k]);
      pd[k]                = m_dir[k][0];
    end
    return {px, py, pd};
  endfunction

  function automatic int sx(input int k);
    logic signed [CORDW-1:0] v;
    v = sprx[k*CORDW +: CORDW];
    return int'(v);
  endfunction

  function automatic int sy(input int k);
    logic signed [CORDW-1:0] v;
    v = spry[k*CORDW +: CORDW];
    return int'(v);
  endfunction

  // driver tasks
  task automatic set_cfg(input int idx, x, y, spd, dv, mode);
    cfg_idx  = IDXW'(idx);
    cfg_x    = CORDW'(x);
    cfg_y    = CORDW'(y);
    cfg_spd  = SPDW'(spd);
    cfg_div  = DIVW'(dv);
    cfg_mode = 2'(mode);
    lc_idx = idx; lc_x = x; lc_y = y; lc_spd = spd; lc_div = dv; lc_mode = mode;
  endtask

  task automatic do_cfg(input int idx, x, y, spd, dv, mode);
    @(negedge clk_pix);
    set_cfg(idx, x, y, spd, dv, mode);
    cfg_we = 1'b1;
    @(negedge clk_pix);
    cfg_we = 1'b0;
    model_cfg(idx, x, y, spd, dv, mode);
  endtask

  // One frame pass. inj: during the pass also pulse cfg_we and frame (both must be refused).
  // same_cfg: cfg_we is raised together with frame using the last set_cfg values.
  task automatic run_frame(input bit inj, input bit same_cfg);
    int cnt;
    bit got;
    logic [W-1:0] e;
    @(negedge clk_pix);
    frame = 1'b1;
    if (same_cfg) begin
      cfg_we = 1'b1;
      model_cfg(lc_idx, lc_x, lc_y, lc_spd, lc_div, lc_mode);
    end
    model_frame();
    exp_q.push_back(model_pack());
    cnt = 0;
    got = 1'b0;
    while (cnt < N + 4) begin
      @(negedge clk_pix);
      cnt++;
      if (cnt == 1) begin
        chk("busy_ready", cfg_ready, 0);
        frame  = inj;
        cfg_we = inj;
        if (inj) set_cfg(0, 5, 5, 1, 0, 0);
      end else if (cnt == 2) begin
        frame  = 1'b0;
        cfg_we = 1'b0;
      end
      if (upd_done) begin
        got = 1'b1;
        break;
      end
    end
    frame  = 1'b0;
    cfg_we = 1'b0;
    chk("upd_lat", got ? cnt : -1, N + 1);
    e = exp_q.pop_front();
    chk_vec("pass_pos", {sprx, spry, dir}, e);
    chk("done_ready", cfg_ready, 1);
    @(negedge clk_pix);
    chk("upd_pulse", upd_done, 0);
  endtask

  typedef struct {
    int idx; int x; int y; int spd; int dv; int mode; int nfr; int ex; int edir;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int exp0[4];
    int seen;
    rst_pix_n = 1'b0; frame = 1'b0; pause = 1'b0; cfg_we = 1'b0; clr_err = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    model_reset();

    vecs[0]  = '{1, -126, 50,  2, 0, 1, 1,  -128, 0};
    vecs[1]  = '{1, -126, 50,  2, 0, 1, 2,   640, 0};
    vecs[2]  = '{2,  510, 60,  4, 0, 3, 1,   512, 0};
    vecs[3]  = '{2,  510, 60,  4, 0, 3, 2,   508, 0};
    vecs[4]  = '{2,  510, 70, 15, 0, 3, 35,    2, 0};
    vecs[5]  = '{2,  510, 70, 15, 0, 3, 36,    0, 1};
    vecs[6]  = '{2,  510, 70, 15, 0, 3, 37,   15, 1};
    vecs[7]  = '{0,  639, -20, 4, 0, 2, 1,   643, 1};
    vecs[8]  = '{0,  639, -20, 4, 0, 2, 2,  -128, 1};
    vecs[9]  = '{0,  100, 10,  7, 0, 0, 3,   100, 0};
    vecs[10] = '{1,  300, 0,   3, 2, 1, 3,   297, 0};
    vecs[11] = '{1,  300, 0,   3, 2, 1, 2,   300, 0};

    // reset state
    repeat (3) @(negedge clk_pix);
    chk_vec("rst_pos", {sprx, spry, dir}, model_pack());
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", upd_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_state", dbg_state, 0);
    rst_pix_n = 1'b1;

    // default motion: wrap-left, speed 2, every second frame
    exp0 = '{640, 638, 638, 636};
    for (int i = 0; i < 4; i++) begin
      run_frame(0, 0);
      chk("def_x0", sx(0), exp0[i]);
      chk("def_y0", sy(0), 240);
    end

    // table vectors: configure one sprite, run frames, check it
    for (int i = 0; i < 12; i++) begin
      do_cfg(vecs[i].idx, vecs[i].x, vecs[i].y, vecs[i].spd, vecs[i].dv, vecs[i].mode);
      for (int f = 0; f < vecs[i].nfr; f++) run_frame(0, 0);
      chk($sformatf("vec%0d_x", i), sx(vecs[i].idx), vecs[i].ex);
      chk($sformatf("vec%0d_y", i), sy(vecs[i].idx), vecs[i].y);
      chk($sformatf("vec%0d_dir", i), dir[vecs[i].idx], vecs[i].edir);
    end

    // config and frame in the same idle cycle: pass uses the new values
    set_cfg(0, 100, 33, 5, 0, 1);
    run_frame(0, 1);
    chk("samecyc_x0", sx(0), 95);
    chk("samecyc_y0", sy(0), 33);

    // write and frame during a pass are refused and flagged
    run_frame(1, 0);
    chk("busy_x0", sx(0), 90);
    chk("busy_err", cfg_err, 1);
    chk("busy_ovr", overrun, 1);
    @(negedge clk_pix); clr_err = 1'b1;
    @(negedge clk_pix); clr_err = 1'b0;
    chk("clr_err", cfg_err, 0);
    chk("clr_ovr", overrun, 0);
    @(negedge clk_pix); set_cfg(N, 7, 7, 1, 0, 0); cfg_we = 1'b1;
    @(negedge clk_pix); cfg_we = 1'b0;
    chk("badidx_err", cfg_err, 1);
    chk("badidx_ovr", overrun, 0);
    @(negedge clk_pix); cfg_we = 1'b1; clr_err = 1'b1;
    @(negedge clk_pix); cfg_we = 1'b0; clr_err = 1'b0;
    chk("setwins_err", cfg_err, 1);
    @(negedge clk_pix); clr_err = 1'b1;
    @(negedge clk_pix); clr_err = 1'b0;
    chk("clr2_err", cfg_err, 0);
    run_frame(0, 0);

    // pause freezes positions and dividers; release resumes the sequence
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 0);
      chk("pause_x1", sx(1), 297);
    end
    pause = 1'b0;
    run_frame(0, 0);
    chk("resume_x1", sx(1), 294);
    run_frame(0, 0);
    chk("resume2_x1", sx(1), 294);

    // reset in the middle of a pass
    @(negedge clk_pix); frame = 1'b1;
    @(negedge clk_pix); frame = 1'b0;
    @(negedge clk_pix); rst_pix_n = 1'b0;
    #1;
    model_reset();
    chk_vec("midrst_pos", {sprx, spry, dir}, model_pack());
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_done", upd_done, 0);
    chk("midrst_err", cfg_err, 0);
    chk("midrst_ovr", overrun, 0);
    seen = 0;
    repeat (2) @(negedge clk_pix);
    rst_pix_n = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk_pix);
      if (upd_done) seen++;
    end
    chk("midrst_noupd", seen, 0);
    run_frame(0, 0);
    chk("post_rst_x0", sx(0), 640);
    run_frame(0, 0);
    chk("post_rst2_x0", sx(0), 638);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
